multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
Multi-cycle control unit for the NPC core. It replaces single-cycle combinational decode with a sequenced FSM that accepts a fetched instruction over a valid/ready handshake and latches it. It then drives ALU, mux and write-enable controls per phase, handshakes with the LSU for loads and stores, and raises trap/halt for ebreak, illegal encodings and memory timeouts. It is parametrised for RV32E or RV32I register files.

Parameters:
XLEN, 32, instruction/data width
NREG, 16, architectural register count (16 = RV32E, 32 = RV32I); register index >= NREG is illegal
RIDX_W, $clog2(NREG), register index width
MEM_TIMEOUT, 255, max cycles waiting for lsu_done before trapping (1..65535)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ifu_valid  in  1  fetched instruction valid
ifu_inst  in  XLEN  fetched instruction
ifu_ready  out  1  FSM can accept instruction
rd / rs1 / rs2  out  RIDX_W each  latched inst[11:7] / [19:15] / [24:20], truncated
imm_type  out  3  0=I,1=S,2=B,3=U,4=J
aluc  out  4  ADD=0 SUB=1 SLTU=2 XOR=3 OR=4 SRA=5 SRL=6 BEQ=7 BNE=8 ADD_JALR=9
src1_pc  out  1  ALU A = pc (AUIPC/JAL)
src2_imm  out  1  ALU B = imm
wb_sel  out  2  0=alu result, 1=mem data, 2=pc+4
lsu_req  out  1  memory request, held until lsu_done
lsu_wen  out  1  request is store
lsu_wmask  out  8  0x0F word, 0x03 half
lsu_done  in  1  memory response
br_taken  in  1  ALU compare result
reg_we  out  1  one-cycle register write pulse
pc_we  out  1  one-cycle PC update pulse
pc_sel  out  1  0=pc+4, 1=alu target (jump or taken branch)
halt  out  1  sticky, core stopped
trap_code  out  3  0=none,1=ebreak,2=illegal,3=mem timeout
perf_cycles / perf_instret  out  32 each  see Optional Feature

Behaviour:
- States: IDLE(0) -> DECODE(1) -> EXEC(2) -> [MEM(3)] -> WB(4) -> IDLE; TRAP(5) absorbing.
- Reset (async, rst_n=0): state=IDLE; instruction register=0x00000013 (nop); all outputs 0 except ifu_ready=1; timeout counter=0.
- IDLE: ifu_ready=1. On ifu_valid&&ifu_ready, latch ifu_inst and go to DECODE. No other output is active.
- DECODE: decode the latched instruction using the RV32 opcode/funct3/funct7 rules below.
  - Supported R: add, sub, sltu, xor, or.
  - Supported I: addi, sltiu, srli, srai.
  - Supported load/store: lw, sh, sw.
  - Supported branch/jump/upper: beq, bne, auipc, jal, jalr.
  - ebreak (0x00100073) -> TRAP with code 1.
  - Any other encoding, or any used register field >= NREG -> TRAP with code 2.
- EXEC: ALU controls are valid. Loads/stores go to MEM with lsu_req=1 asserted in the same cycle as entry. All other instructions go to WB.
- MEM: lsu_req, lsu_wen and lsu_wmask are held stable until lsu_done. Timeout counter increments each cycle.
  - lsu_done -> WB; counter clears.
  - Counter reaching MEM_TIMEOUT with no lsu_done -> TRAP with code 3; lsu_req drops.
  - lsu_done arriving in the same cycle as expiry: done wins.
- WB: pc_we=1 for one cycle. reg_we=1 unless the instruction is a store or branch, or rd==0.
  - pc_sel=1 for jal/jalr; for beq/bne, pc_sel=1 when br_taken is sampled in WB.
  - Then go to IDLE.
- Control outputs (aluc, sel bits, rd/rs) are registered off the latched instruction and stable DECODE..WB.
- Every fetch-to-retire takes 4 cycles (non-memory) or 4+N cycles (memory, N = cycles until lsu_done).
- TRAP: halt=1 and trap_code held; ifu_ready=0. Only reset exits.
- Reset mid-MEM aborts lsu_req immediately (async).

Optional Feature:
CU_PERF_EN:
- Defined: perf_cycles increments every cycle outside TRAP; perf_instret increments on each WB. Both wrap at 2^32 and reset to 0.
- Undefined: both ports are driven constant 0 and no counter flops are synthesised.

Test Plan:
- add x3,x1,x2 (0x002081B3), ifu_valid held -> ifu_ready low 3 cycles; aluc=0, wb_sel=0; reg_we and pc_we pulse in cycle 4, pc_sel=0.
- sw x2,4(x1) (0x0020A223), lsu_done after 3 cycles -> lsu_req high 3 cycles, lsu_wen=1, wmask=0x0F; reg_we=0 in WB.
- lw x5,0(x1) (0x0000A283), lsu_done never, MEM_TIMEOUT=8 -> halt=1, trap_code=3 after 8 MEM cycles; lsu_req=0 afterwards.
- NREG=16, add x20,x1,x2 (0x00208A33) -> trap_code=2, halt=1; NREG=32 -> retires normally.
- bne with br_taken=1 -> pc_sel=1 in WB; with br_taken=0 -> pc_sel=0; reg_we=0 both cases.
- ebreak (0x00100073) -> trap_code=1 after DECODE; rst_n pulse -> IDLE, ifu_ready=1, outputs 0; with CU_PERF_EN the counters read 0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_if.sv
// Fetch and load/store handshake bundle between the multi-cycle control FSM and the core datapath.
// master: datapath/IFU/LSU side; slave: the control FSM.
interface multicycle_ctrl_fsm_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            ifu_valid;
    logic [XLEN-1:0] ifu_inst;
    logic            ifu_ready;
    logic            lsu_req;
    logic            lsu_wen;
    logic [7:0]      lsu_wmask;
    logic            lsu_done;

    modport master (
        output ifu_valid,
        output ifu_inst,
        output lsu_done,
        input  ifu_ready,
        input  lsu_req,
        input  lsu_wen,
        input  lsu_wmask
    );

    modport slave (
        input  ifu_valid,
        input  ifu_inst,
        input  lsu_done,
        output ifu_ready,
        output lsu_req,
        output lsu_wen,
        output lsu_wmask
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle NPC control unit: IDLE -> DECODE -> EXEC -> [MEM] -> WB, with an absorbing TRAP state.
// Defining CU_PERF_EN adds free-running cycle and retired-instruction counters.
module multicycle_ctrl_fsm #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NREG        = 16,
    parameter int unsigned RIDX_W      = $clog2(NREG),
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_ctrl_fsm_if.slave bus,
    output logic [RIDX_W-1:0]    rd,
    output logic [RIDX_W-1:0]    rs1,
    output logic [RIDX_W-1:0]    rs2,
    output logic [2:0]           imm_type,
    output logic [3:0]           aluc,
    output logic                 src1_pc,
    output logic                 src2_imm,
    output logic [1:0]           wb_sel,
    input  logic                 br_taken,
    output logic                 reg_we,
    output logic                 pc_we,
    output logic                 pc_sel,
    output logic                 halt,
    output logic [2:0]           trap_code,
    output logic [31:0]          perf_cycles,
    output logic [31:0]          perf_instret
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    typedef struct packed {
        logic       illegal;
        logic [2:0] imm_type;
        logic [3:0] aluc;
        logic       src1_pc;
        logic       src2_imm;
        logic [1:0] wb_sel;
        logic       is_mem;
        logic       is_store;
        logic [7:0] wmask;
        logic       writes_rd;
        logic       is_jump;
        logic       is_branch;
        logic       use_rd;
        logic       use_rs1;
        logic       use_rs2;
    } dec_t;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluSltu = 4'd2;
    localparam logic [3:0] AluXor  = 4'd3;
    localparam logic [3:0] AluOr   = 4'd4;
    localparam logic [3:0] AluSra  = 4'd5;
    localparam logic [3:0] AluSrl  = 4'd6;
    localparam logic [3:0] AluBeq  = 4'd7;
    localparam logic [3:0] AluBne  = 4'd8;
    localparam logic [3:0] AluJalr = 4'd9;

    localparam logic [2:0] ImmI = 3'd0;
    localparam logic [2:0] ImmS = 3'd1;
    localparam logic [2:0] ImmB = 3'd2;
    localparam logic [2:0] ImmU = 3'd3;
    localparam logic [2:0] ImmJ = 3'd4;

    localparam logic [2:0] TrapNone    = 3'd0;
    localparam logic [2:0] TrapEbreak  = 3'd1;
    localparam logic [2:0] TrapIllegal = 3'd2;
    localparam logic [2:0] TrapMemTmo  = 3'd3;

    localparam logic [15:0] TmoLast = 16'(MEM_TIMEOUT - 1);

    state_e          state_q;
    logic [XLEN-1:0] inst_q;
    logic            ready_q;
    logic            lsu_req_q;
    logic            lsu_wen_q;
    logic [7:0]      lsu_wmask_q;
    logic            reg_we_q;
    logic            pc_we_q;
    logic            halt_q;
    logic [2:0]      trap_code_q;
    logic [15:0]     tmo_q;

    dec_t       dec;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       bad_reg;
    logic [2:0] dec_trap;
    logic       wb_we;
    logic       active;

    assign op = inst_q[6:0];
    assign f3 = inst_q[14:12];
    assign f7 = inst_q[31:25];

    always_comb begin
        dec         = '0;
        dec.illegal = 1'b1;
        dec.wmask   = 8'h0F;
        case (op)
            7'b0110011: begin
                dec.use_rd    = 1'b1;
                dec.use_rs1   = 1'b1;
                dec.use_rs2   = 1'b1;
                dec.writes_rd = 1'b1;
                dec.illegal   = 1'b0;
                case ({f7, f3})
                    {7'h00, 3'd0}: dec.aluc = AluAdd;
                    {7'h20, 3'd0}: dec.aluc = AluSub;
                    {7'h00, 3'd3}: dec.aluc = AluSltu;
                    {7'h00, 3'd4}: dec.aluc = AluXor;
                    {7'h00, 3'd6}: dec.aluc = AluOr;
                    default:       dec.illegal = 1'b1;
                endcase
            end
            7'b0010011: begin
                dec.use_rd    = 1'b1;
                dec.use_rs1   = 1'b1;
                dec.writes_rd = 1'b1;
                dec.src2_imm  = 1'b1;
                dec.imm_type  = ImmI;
                dec.illegal   = 1'b0;
                case (f3)
                    3'd0: dec.aluc = AluAdd;
                    3'd3: dec.aluc = AluSltu;
                    3'd5: begin
                        if (f7 == 7'h00) begin
                            dec.aluc = AluSrl;
                        end else if (f7 == 7'h20) begin
                            dec.aluc = AluSra;
                        end else begin
                            dec.illegal = 1'b1;
                        end
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            7'b0000011: begin
                dec.use_rd    = 1'b1;
                dec.use_rs1   = 1'b1;
                dec.writes_rd = 1'b1;
                dec.src2_imm  = 1'b1;
                dec.imm_type  = ImmI;
                dec.wb_sel    = 2'd1;
                dec.is_mem    = 1'b1;
                dec.illegal   = (f3 != 3'd2);
            end
            7'b0100011: begin
                dec.use_rs1  = 1'b1;
                dec.use_rs2  = 1'b1;
                dec.src2_imm = 1'b1;
                dec.imm_type = ImmS;
                dec.is_mem   = 1'b1;
                dec.is_store = 1'b1;
                dec.wmask    = (f3 == 3'd1) ? 8'h03 : 8'h0F;
                dec.illegal  = (f3 != 3'd1) && (f3 != 3'd2);
            end
            7'b1100011: begin
                dec.use_rs1   = 1'b1;
                dec.use_rs2   = 1'b1;
                dec.imm_type  = ImmB;
                dec.is_branch = 1'b1;
                dec.aluc      = (f3 == 3'd1) ? AluBne : AluBeq;
                dec.illegal   = (f3 != 3'd0) && (f3 != 3'd1);
            end
            7'b0010111: begin
                dec.use_rd    = 1'b1;
                dec.writes_rd = 1'b1;
                dec.src1_pc   = 1'b1;
                dec.src2_imm  = 1'b1;
                dec.imm_type  = ImmU;
                dec.illegal   = 1'b0;
            end
            7'b1101111: begin
                dec.use_rd    = 1'b1;
                dec.writes_rd = 1'b1;
                dec.src1_pc   = 1'b1;
                dec.src2_imm  = 1'b1;
                dec.imm_type  = ImmJ;
                dec.wb_sel    = 2'd2;
                dec.is_jump   = 1'b1;
                dec.illegal   = 1'b0;
            end
            7'b1100111: begin
                dec.use_rd    = 1'b1;
                dec.use_rs1   = 1'b1;
                dec.writes_rd = 1'b1;
                dec.src2_imm  = 1'b1;
                dec.imm_type  = ImmI;
                dec.aluc      = AluJalr;
                dec.wb_sel    = 2'd2;
                dec.is_jump   = 1'b1;
                dec.illegal   = (f3 != 3'd0);
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Only fields the instruction actually uses are range-checked against the register file.
    assign bad_reg = (dec.use_rd  && (32'(inst_q[11:7])  >= NREG)) ||
                     (dec.use_rs1 && (32'(inst_q[19:15]) >= NREG)) ||
                     (dec.use_rs2 && (32'(inst_q[24:20]) >= NREG));

    always_comb begin
        dec_trap = TrapNone;
        if (inst_q[31:0] == 32'h0010_0073) begin
            dec_trap = TrapEbreak;
        end else if (dec.illegal || bad_reg) begin
            dec_trap = TrapIllegal;
        end
    end

    assign wb_we = dec.writes_rd && (inst_q[11:7] != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            inst_q      <= XLEN'(32'h0000_0013);
            ready_q     <= 1'b1;
            lsu_req_q   <= 1'b0;
            lsu_wen_q   <= 1'b0;
            lsu_wmask_q <= 8'h00;
            reg_we_q    <= 1'b0;
            pc_we_q     <= 1'b0;
            halt_q      <= 1'b0;
            trap_code_q <= TrapNone;
            tmo_q       <= 16'd0;
        end else begin
            reg_we_q <= 1'b0;
            pc_we_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.ifu_valid && ready_q) begin
                        inst_q  <= bus.ifu_inst;
                        ready_q <= 1'b0;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    if (dec_trap != TrapNone) begin
                        halt_q      <= 1'b1;
                        trap_code_q <= dec_trap;
                        state_q     <= StTrap;
                    end else begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (dec.is_mem) begin
                        lsu_req_q   <= 1'b1;
                        lsu_wen_q   <= dec.is_store;
                        lsu_wmask_q <= dec.wmask;
                        tmo_q       <= 16'd0;
                        state_q     <= StMem;
                    end else begin
                        pc_we_q  <= 1'b1;
                        reg_we_q <= wb_we;
                        state_q  <= StWb;
                    end
                end
                StMem: begin
                    // A response in the expiry cycle still completes the access.
                    if (bus.lsu_done) begin
                        lsu_req_q   <= 1'b0;
                        lsu_wen_q   <= 1'b0;
                        lsu_wmask_q <= 8'h00;
                        tmo_q       <= 16'd0;
                        pc_we_q     <= 1'b1;
                        reg_we_q    <= wb_we;
                        state_q     <= StWb;
                    end else if (tmo_q == TmoLast) begin
                        lsu_req_q   <= 1'b0;
                        lsu_wen_q   <= 1'b0;
                        lsu_wmask_q <= 8'h00;
                        halt_q      <= 1'b1;
                        trap_code_q <= TrapMemTmo;
                        state_q     <= StTrap;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                StWb: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                StTrap: begin
                    state_q <= StTrap;
                end
                default: begin
                    state_q <= StTrap;
                end
            endcase
        end
    end

    assign active = (state_q == StDecode) || (state_q == StExec) ||
                    (state_q == StMem) || (state_q == StWb);

    assign rd       = active ? inst_q[7 +: RIDX_W]  : '0;
    assign rs1      = active ? inst_q[15 +: RIDX_W] : '0;
    assign rs2      = active ? inst_q[20 +: RIDX_W] : '0;
    assign imm_type = active ? dec.imm_type : 3'd0;
    assign aluc     = active ? dec.aluc : 4'd0;
    assign src1_pc  = active && dec.src1_pc;
    assign src2_imm = active && dec.src2_imm;
    assign wb_sel   = active ? dec.wb_sel : 2'd0;
    // Branch outcome is only meaningful once the ALU has settled, i.e. in WB.
    assign pc_sel   = (state_q == StWb) && (dec.is_jump || (dec.is_branch && br_taken));

    assign bus.ifu_ready = ready_q;
    assign bus.lsu_req   = lsu_req_q;
    assign bus.lsu_wen   = lsu_wen_q;
    assign bus.lsu_wmask = lsu_wmask_q;
    assign reg_we        = reg_we_q;
    assign pc_we         = pc_we_q;
    assign halt          = halt_q;
    assign trap_code     = trap_code_q;

`ifdef CU_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q  <= 32'd0;
            perf_instret_q <= 32'd0;
        end else begin
            if (state_q != StTrap) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if (state_q == StWb) begin
                perf_instret_q <= perf_instret_q + 32'd1;
            end
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_instret = perf_instret_q;
`else
    assign perf_cycles  = 32'd0;
    assign perf_instret = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: an RV32E instance (MEM_TIMEOUT=8) carries most traffic,
// an RV32I instance confirms that high register indices retire.
module tb_multicycle_ctrl_fsm;

    typedef struct {
        logic [2:0] code;
        logic       reg_we;
        logic       pc_sel;
        logic [3:0] aluc;
        logic [1:0] wb_sel;
        logic [4:0] rd;
        int         cycles;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic br_taken;

    int n_checks = 0;
    int n_fails  = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.XLEN(32)) bus_a ();
    multicycle_ctrl_fsm_if #(.XLEN(32)) bus_b ();

    logic [3:0]  a_rd, a_rs1, a_rs2, a_aluc;
    logic [2:0]  a_imm_type, a_trap_code;
    logic        a_src1_pc, a_src2_imm, a_reg_we, a_pc_we, a_pc_sel, a_halt;
    logic [1:0]  a_wb_sel;
    logic [31:0] a_perf_cycles, a_perf_instret;

    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [3:0]  b_aluc;
    logic [2:0]  b_imm_type, b_trap_code;
    logic        b_src1_pc, b_src2_imm, b_reg_we, b_pc_we, b_pc_sel, b_halt;
    logic [1:0]  b_wb_sel;
    logic [31:0] b_perf_cycles, b_perf_instret;

    multicycle_ctrl_fsm #(.XLEN(32), .NREG(16), .MEM_TIMEOUT(8)) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_a.slave),
        .rd           (a_rd),
        .rs1          (a_rs1),
        .rs2          (a_rs2),
        .imm_type     (a_imm_type),
        .aluc         (a_aluc),
        .src1_pc      (a_src1_pc),
        .src2_imm     (a_src2_imm),
        .wb_sel       (a_wb_sel),
        .br_taken     (br_taken),
        .reg_we       (a_reg_we),
        .pc_we        (a_pc_we),
        .pc_sel       (a_pc_sel),
        .halt         (a_halt),
        .trap_code    (a_trap_code),
        .perf_cycles  (a_perf_cycles),
        .perf_instret (a_perf_instret)
    );

    multicycle_ctrl_fsm #(.XLEN(32), .NREG(32)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_b.slave),
        .rd           (b_rd),
        .rs1          (b_rs1),
        .rs2          (b_rs2),
        .imm_type     (b_imm_type),
        .aluc         (b_aluc),
        .src1_pc      (b_src1_pc),
        .src2_imm     (b_src2_imm),
        .wb_sel       (b_wb_sel),
        .br_taken     (br_taken),
        .reg_we       (b_reg_we),
        .pc_we        (b_pc_we),
        .pc_sel       (b_pc_sel),
        .halt         (b_halt),
        .trap_code    (b_trap_code),
        .perf_cycles  (b_perf_cycles),
        .perf_instret (b_perf_instret)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_wb(input logic [4:0] rd, input logic [3:0] aluc, input logic [1:0] wb_sel,
                             input logic reg_we, input logic pc_sel, input int cycles);
        exp_t e;
        e.code = 3'd0; e.reg_we = reg_we; e.pc_sel = pc_sel; e.aluc = aluc;
        e.wb_sel = wb_sel; e.rd = rd; e.cycles = cycles;
        sb_q.push_back(e);
    endtask

    task automatic expect_trap(input logic [2:0] code, input int cycles);
        exp_t e;
        e.code = code; e.reg_we = 1'b0; e.pc_sel = 1'b0; e.aluc = 4'd0;
        e.wb_sel = 2'd0; e.rd = 5'd0; e.cycles = cycles;
        sb_q.push_back(e);
    endtask

    task automatic send_a(input logic [31:0] inst);
        bit ok = 1'b0;
        @(posedge clk); #1;
        bus_a.ifu_valid = 1'b1;
        bus_a.ifu_inst  = inst;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_a.ifu_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        bus_a.ifu_valid = 1'b0;
        check_eq("send_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle_a;
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_a.ifu_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("back_to_idle", 32'(ok), 32'd1);
    endtask

    task automatic wait_halt_a;
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_halt) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("halt_reached", 32'(ok), 32'd1);
    endtask

    task automatic run_alu(input logic [31:0] inst, input logic [4:0] rd, input logic [3:0] aluc,
                           input logic [1:0] wb_sel, input logic reg_we, input logic pc_sel);
        expect_wb(rd, aluc, wb_sel, reg_we, pc_sel, 4);
        send_a(inst);
        wait_idle_a();
    endtask

    // Memory op whose response arrives in the n-th MEM cycle (n >= 2).
    task automatic run_mem(input logic [31:0] inst, input int n, input logic wen,
                           input logic [7:0] wmask);
        bit ok = 1'b0;
        send_a(inst);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_a.lsu_req) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("lsu_req_rise", 32'(ok), 32'd1);
        check_eq("lsu_wen", 32'(bus_a.lsu_wen), 32'(wen));
        check_eq("lsu_wmask", 32'(bus_a.lsu_wmask), 32'(wmask));
        for (int i = 2; i <= n; i++) begin
            @(posedge clk); #1;
            if (i == n) bus_a.lsu_done = 1'b1;
            @(negedge clk);
            check_eq("lsu_req_held", 32'(bus_a.lsu_req), 32'd1);
            check_eq("lsu_wmask_held", 32'(bus_a.lsu_wmask), 32'(wmask));
        end
        @(posedge clk); #1;
        bus_a.lsu_done = 1'b0;
        @(negedge clk);
        check_eq("lsu_req_drop", 32'(bus_a.lsu_req), 32'd0);
        wait_idle_a();
    endtask

    task automatic do_reset;
        @(posedge clk); #2;
        bus_a.ifu_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_ifu_ready", 32'(bus_a.ifu_ready), 32'd1);
        check_eq("rst_halt", 32'(a_halt), 32'd0);
        check_eq("rst_trap_code", 32'(a_trap_code), 32'd0);
        check_eq("rst_lsu_req", 32'(bus_a.lsu_req), 32'd0);
        check_eq("rst_pc_we", 32'(a_pc_we), 32'd0);
        check_eq("rst_aluc", 32'(a_aluc), 32'd0);
        check_eq("rst_perf_cycles", a_perf_cycles, 32'd0);
        check_eq("rst_perf_instret", a_perf_instret, 32'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
    endtask

    // Scoreboard side: pops one expectation per retirement (pc_we) or trap entry.
    initial begin : monitor
        int cyc;
        bit busy;
        bit halt_seen;
        exp_t e;
        cyc = 0;
        busy = 1'b0;
        halt_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 1'b0;
                halt_seen = 1'b0;
            end else begin
                if (busy) cyc++;
                if (bus_a.ifu_valid && bus_a.ifu_ready) begin
                    busy = 1'b1;
                    cyc = 1;
                end
                if (a_pc_we || (a_halt && !halt_seen)) begin
                    if (sb_q.size() == 0) begin
                        check_eq("sb_nonempty", 32'(sb_q.size()), 32'd1);
                    end else begin
                        e = sb_q.pop_front();
                        check_eq("trap_code", 32'(a_trap_code), 32'(e.code));
                        check_eq("event_cycle", 32'(cyc), 32'(e.cycles));
                        if (a_halt) begin
                            halt_seen = 1'b1;
                        end else begin
                            check_eq("wb_reg_we", 32'(a_reg_we), 32'(e.reg_we));
                            check_eq("wb_pc_sel", 32'(a_pc_sel), 32'(e.pc_sel));
                            check_eq("wb_aluc", 32'(a_aluc), 32'(e.aluc));
                            check_eq("wb_sel", 32'(a_wb_sel), 32'(e.wb_sel));
                            check_eq("wb_rd", 32'(a_rd), 32'(e.rd));
                        end
                    end
                    busy = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit ok;
        rst_n = 1'b0;
        br_taken = 1'b0;
        bus_a.ifu_valid = 1'b0;
        bus_a.ifu_inst  = 32'd0;
        bus_a.lsu_done  = 1'b0;
        bus_b.ifu_valid = 1'b0;
        bus_b.ifu_inst  = 32'd0;
        bus_b.lsu_done  = 1'b0;
        do_reset();

        // add x3,x1,x2 with ifu_valid held through the whole instruction
        expect_wb(5'd3, 4'd0, 2'd0, 1'b1, 1'b0, 4);
        @(posedge clk); #1;
        bus_a.ifu_valid = 1'b1;
        bus_a.ifu_inst  = 32'h0020_81B3;
        @(negedge clk);
        check_eq("add_ready_idle", 32'(bus_a.ifu_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("add_ready_busy", 32'(bus_a.ifu_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus_a.ifu_valid = 1'b0;
        @(negedge clk);
        check_eq("add_ready_again", 32'(bus_a.ifu_ready), 32'd1);
        check_eq("reg_we_one_pulse", 32'(a_reg_we), 32'd0);
        check_eq("pc_we_one_pulse", 32'(a_pc_we), 32'd0);
`ifdef CU_PERF_EN
        check_eq("perf_instret_one", a_perf_instret, 32'd1);
`endif

        run_alu(32'h0000_0013, 5'd0,  4'd0, 2'd0, 1'b0, 1'b0);  // nop, rd=0
        run_alu(32'h4083_8333, 5'd6,  4'd1, 2'd0, 1'b1, 1'b0);  // sub
        run_alu(32'h0020_B4B3, 5'd9,  4'd2, 2'd0, 1'b1, 1'b0);  // sltu
        run_alu(32'h0020_C533, 5'd10, 4'd3, 2'd0, 1'b1, 1'b0);  // xor
        run_alu(32'h0020_E5B3, 5'd11, 4'd4, 2'd0, 1'b1, 1'b0);  // or
        run_alu(32'h0050_B613, 5'd12, 4'd2, 2'd0, 1'b1, 1'b0);  // sltiu
        run_alu(32'h4030_D693, 5'd13, 4'd5, 2'd0, 1'b1, 1'b0);  // srai
        run_alu(32'h0030_D713, 5'd14, 4'd6, 2'd0, 1'b1, 1'b0);  // srli
        run_alu(32'h1234_5797, 5'd15, 4'd0, 2'd0, 1'b1, 1'b0);  // auipc
        run_alu(32'h0080_00EF, 5'd1,  4'd0, 2'd2, 1'b1, 1'b1);  // jal x1,8
        run_alu(32'h0000_8067, 5'd0,  4'd9, 2'd2, 1'b0, 1'b1);  // jalr x0,0(x1)
        br_taken = 1'b1;
        run_alu(32'h0020_9463, 5'd8,  4'd8, 2'd0, 1'b0, 1'b1);  // bne taken
        run_alu(32'h0020_8463, 5'd8,  4'd7, 2'd0, 1'b0, 1'b1);  // beq taken
        br_taken = 1'b0;
        run_alu(32'h0020_9463, 5'd8,  4'd8, 2'd0, 1'b0, 1'b0);  // bne not taken

        expect_wb(5'd4, 4'd0, 2'd0, 1'b0, 1'b0, 7);
        run_mem(32'h0020_A223, 3, 1'b1, 8'h0F);                  // sw x2,4(x1)
        expect_wb(5'd6, 4'd0, 2'd0, 1'b0, 1'b0, 6);
        run_mem(32'h0020_9323, 2, 1'b1, 8'h03);                  // sh x2,6(x1)
        expect_wb(5'd5, 4'd0, 2'd1, 1'b1, 1'b0, 7);
        run_mem(32'h0000_A283, 3, 1'b0, 8'h0F);                  // lw x5,0(x1)

        // Decode-time traps
        expect_trap(3'd2, 3);
        send_a(32'h0000_8283);                                   // lb: unsupported
        wait_halt_a();
        do_reset();
        expect_trap(3'd2, 3);
        send_a(32'h0020_8A33);                                   // add x20: beyond RV32E
        wait_halt_a();
        do_reset();
        expect_trap(3'd1, 3);
        send_a(32'h0010_0073);                                   // ebreak
        wait_halt_a();
        check_eq("ebreak_not_ready", 32'(bus_a.ifu_ready), 32'd0);
        do_reset();

        // Memory timeout: 8 MEM cycles without lsu_done
        expect_trap(3'd3, 12);
        send_a(32'h0000_A283);
        wait_halt_a();
        check_eq("tmo_lsu_req_low", 32'(bus_a.lsu_req), 32'd0);
        @(posedge clk); #1;
        bus_a.ifu_valid = 1'b1;
        bus_a.ifu_inst  = 32'h0020_81B3;
        repeat (3) @(negedge clk);
        check_eq("trap_sticky_halt", 32'(a_halt), 32'd1);
        check_eq("trap_sticky_code", 32'(a_trap_code), 32'd3);
        check_eq("trap_not_ready", 32'(bus_a.ifu_ready), 32'd0);
        do_reset();

        // Asynchronous reset during MEM drops lsu_req immediately
        send_a(32'h0000_A283);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_a.lsu_req) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("abort_lsu_req_rise", 32'(ok), 32'd1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_lsu_req_low", 32'(bus_a.lsu_req), 32'd0);
        check_eq("abort_ready", 32'(bus_a.ifu_ready), 32'd1);
        @(negedge clk); #2;
        rst_n = 1'b1;

        // RV32I instance retires add x20,x1,x2
        @(posedge clk); #1;
        bus_b.ifu_valid = 1'b1;
        bus_b.ifu_inst  = 32'h0020_8A33;
        @(negedge clk);
        check_eq("b_ready", 32'(bus_b.ifu_ready), 32'd1);
        @(posedge clk); #1;
        bus_b.ifu_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b_pc_we) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("b_retired", 32'(ok), 32'd1);
        check_eq("b_reg_we", 32'(b_reg_we), 32'd1);
        check_eq("b_rd", 32'(b_rd), 32'd20);
        check_eq("b_halt", 32'(b_halt), 32'd0);

        repeat (2) @(negedge clk);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
